// File: rtl/wire_alu_pkg.sv
// Shared encodings for the wire-in ALU bank: op modes, lane states and counter width.
package wire_alu_pkg;

  localparam int unsigned OP_COUNT_W = 16;

  typedef enum logic [1:0] {
    ModeAdd = 2'b00,
    ModeSub = 2'b01,
    ModeAcc = 2'b10,
    ModeClr = 2'b11
  } alu_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCapt = 2'b01,
    StExec = 2'b10
  } lane_state_e;

endpackage

// File: rtl/wire_alu_lane.sv
// One ALU channel: start-edge capture, IDLE->CAPT->EXEC sequencing and sticky status.
// Define WIRE_ALU_SAT_EN to clamp overflowing results instead of wrapping.
module wire_alu_lane
  import wire_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_ovf,
  output logic             o_err,
  output logic             o_complete
);

  lane_state_e      r_state;
  alu_mode_e        r_mode;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_start_q;
  logic             r_done;
  logic             r_ovf;
  logic             r_err;

  logic             w_edge;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_next_r;
  logic             w_flow;

  assign w_edge = i_start & ~r_start_q;

  // Top bit of the WIDTH+1 result is the carry for ADD/ACC and the borrow for SUB.
  always_comb begin
    w_sum    = '0;
    w_flow   = 1'b0;
    unique case (r_mode)
      ModeAdd: w_sum = {1'b0, r_a} + {1'b0, r_b};
      ModeSub: w_sum = {1'b0, r_a} - {1'b0, r_b};
      ModeAcc: w_sum = {1'b0, r_result} + {1'b0, r_a};
      ModeClr: w_sum = '0;
    endcase
    w_flow   = (r_mode != ModeClr) & w_sum[WIDTH];
    w_next_r = w_sum[WIDTH-1:0];
`ifdef WIRE_ALU_SAT_EN
    if (w_flow) begin
      w_next_r = (r_mode == ModeSub) ? '0 : '1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_mode    <= ModeAdd;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_start_q <= 1'b1;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_start_q <= i_start;
      case (r_state)
        StIdle: begin
          if (w_edge) begin
            r_state <= StCapt;
            r_mode  <= alu_mode_e'(i_mode);
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_done  <= 1'b0;
          end
        end
        StCapt: r_state <= StExec;
        StExec: begin
          r_state  <= StIdle;
          r_result <= w_next_r;
          r_done   <= 1'b1;
          if (r_mode == ModeClr) begin
            r_ovf <= 1'b0;
            r_err <= 1'b0;
          end else if (w_flow) begin
            r_ovf <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
      // A dropped edge lands after a completing CLR, so it stays visible.
      if (w_edge && (r_state != StIdle)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_result   = r_result;
  assign o_done     = r_done;
  assign o_busy     = (r_state != StIdle);
  assign o_ovf      = r_ovf;
  assign o_err      = r_err;
  assign o_complete = (r_state == StExec);

endmodule

// File: rtl/wire_alu_bank.sv
// Bank of NCH independent ALU lanes with inverted LED wire-in and a shared op counter.
// Define WIRE_ALU_SAT_EN to build saturating lanes.
module wire_alu_bank
  import wire_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 2,
  parameter int unsigned LED_W = 4
) (
  input  logic                  okClk,
  input  logic                  reset,
  input  logic [LED_W-1:0]      led_ctrl,
  output logic [LED_W-1:0]      led,
  input  logic [NCH*WIDTH-1:0]  op_a,
  input  logic [NCH*WIDTH-1:0]  op_b,
  input  logic [NCH*2-1:0]      mode,
  input  logic [NCH-1:0]        start,
  output logic [NCH*WIDTH-1:0]  result,
  output logic [NCH-1:0]        done,
  output logic [NCH-1:0]        busy,
  output logic [NCH-1:0]        ovf,
  output logic [NCH-1:0]        err,
  output logic [OP_COUNT_W-1:0] op_count
);

  logic [LED_W-1:0]      r_led;
  logic [OP_COUNT_W-1:0] r_op_count;
  logic [OP_COUNT_W-1:0] w_ops;
  logic [NCH-1:0]        w_complete;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    wire_alu_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .i_clk      (okClk),
      .i_rst      (reset),
      .i_start    (start[c]),
      .i_mode     (mode[c*2 +: 2]),
      .i_op_a     (op_a[c*WIDTH +: WIDTH]),
      .i_op_b     (op_b[c*WIDTH +: WIDTH]),
      .o_result   (result[c*WIDTH +: WIDTH]),
      .o_done     (done[c]),
      .o_busy     (busy[c]),
      .o_ovf      (ovf[c]),
      .o_err      (err[c]),
      .o_complete (w_complete[c])
    );
  end

  always_comb begin
    w_ops = '0;
    for (int c = 0; c < NCH; c++) begin
      w_ops = w_ops + OP_COUNT_W'(w_complete[c]);
    end
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      r_led      <= '1;
      r_op_count <= '0;
    end else begin
      r_led      <= ~led_ctrl;
      r_op_count <= r_op_count + w_ops;
    end
  end

  assign led      = r_led;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_wire_alu_bank.sv
// Self-checking bench for wire_alu_bank: directed cases plus random traffic against a
// cycle-stamped behavioural model.
module tb_wire_alu_bank;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NCH   = 4;
  localparam int unsigned LED_W = 4;

  logic                 okClk = 1'b0;
  logic                 reset;
  logic [LED_W-1:0]     led_ctrl;
  logic [LED_W-1:0]     led;
  logic [NCH*WIDTH-1:0] op_a;
  logic [NCH*WIDTH-1:0] op_b;
  logic [NCH*2-1:0]     mode;
  logic [NCH-1:0]       start;
  logic [NCH*WIDTH-1:0] result;
  logic [NCH-1:0]       done;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       ovf;
  logic [NCH-1:0]       err;
  logic [15:0]          op_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 okClk = ~okClk;

  wire_alu_bank #(
    .WIDTH(WIDTH),
    .NCH  (NCH),
    .LED_W(LED_W)
  ) dut (
    .okClk   (okClk),
    .reset   (reset),
    .led_ctrl(led_ctrl),
    .led     (led),
    .op_a    (op_a),
    .op_b    (op_b),
    .mode    (mode),
    .start   (start),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .ovf     (ovf),
    .err     (err),
    .op_count(op_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted edge is stamped with the cycle whose edge writes the result.
  logic [WIDTH-1:0] m_r    [NCH];
  logic [WIDTH-1:0] m_a    [NCH];
  logic [WIDTH-1:0] m_b    [NCH];
  logic [1:0]       m_mode [NCH];
  bit               m_done [NCH];
  bit               m_ovf  [NCH];
  bit               m_err  [NCH];
  bit               m_pend [NCH];
  bit               m_prev [NCH];
  longint           m_due  [NCH];
  logic [15:0]      m_cnt;
  logic [LED_W-1:0] m_led;
  longint           cyc = 0;

  function automatic void finish_op(int c);
    longint unsigned a   = m_a[c];
    longint unsigned b   = m_b[c];
    longint unsigned r   = m_r[c];
    longint unsigned top = 64'd1 << WIDTH;
    longint unsigned v   = 0;
    bit flow = 1'b0;
    case (m_mode[c])
      2'd0: begin v = a + b; flow = (v >= top); end
      2'd1: begin flow = (a < b); v = a + top - b; end
      2'd2: begin v = r + a; flow = (v >= top); end
      default: v = 0;
    endcase
    m_r[c] = WIDTH'(v % top);
`ifdef WIRE_ALU_SAT_EN
    if (flow) m_r[c] = (m_mode[c] == 2'd1) ? '0 : '1;
`endif
    if (m_mode[c] == 2'd3) begin
      m_ovf[c] = 1'b0;
      m_err[c] = 1'b0;
    end else if (flow) begin
      m_ovf[c] = 1'b1;
    end
    m_done[c] = 1'b1;
  endfunction

  always @(posedge okClk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_r[c] = '0; m_done[c] = 0; m_ovf[c] = 0; m_err[c] = 0;
        m_pend[c] = 0; m_prev[c] = 1;
      end
      m_cnt = '0;
      m_led = '1;
    end else begin
      m_led = ~led_ctrl;
      for (int c = 0; c < NCH; c++) begin
        bit rise, was_busy;
        rise     = start[c] && !m_prev[c];
        was_busy = m_pend[c];
        m_prev[c] = start[c];
        if (m_pend[c] && cyc == m_due[c]) begin
          finish_op(c);
          m_pend[c] = 0;
          m_cnt++;
        end
        if (rise) begin
          if (was_busy) begin
            m_err[c] = 1'b1;
          end else begin
            m_pend[c] = 1'b1;
            m_due[c]  = cyc + 2;
            m_mode[c] = mode[c*2 +: 2];
            m_a[c]    = op_a[c*WIDTH +: WIDTH];
            m_b[c]    = op_b[c*WIDTH +: WIDTH];
            m_done[c] = 1'b0;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge okClk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("result[%0d]", c), result[c*WIDTH +: WIDTH], m_r[c]);
        check($sformatf("done[%0d]", c), done[c], m_done[c]);
        check($sformatf("busy[%0d]", c), busy[c], m_pend[c]);
        check($sformatf("ovf[%0d]", c), ovf[c], m_ovf[c]);
        check($sformatf("err[%0d]", c), err[c], m_err[c]);
      end
      check("op_count", op_count, m_cnt);
      check("led", led, m_led);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge okClk);
    #1;
  endtask

  task automatic set_op(input int c, input logic [1:0] m, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    mode[c*2 +: 2]       = m;
    op_a[c*WIDTH +: WIDTH] = a;
    op_b[c*WIDTH +: WIDTH] = b;
  endtask

  function automatic logic [WIDTH-1:0] rand_opnd();
    case ($urandom_range(0, 2))
      0:       return WIDTH'($urandom_range(0, 15));
      1:       return {WIDTH{1'b1}} - WIDTH'($urandom_range(0, 15));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = '0; op_a = '0; op_b = '0; mode = '0; led_ctrl = '0;
    @(posedge okClk);
    #1;
    chk_en = 1'b1;
    tick(2);
    check("rst_result0", result[0 +: WIDTH], 0);
    check("rst_op_count", op_count, 0);
    check("rst_led", led, 4'hF);

    reset = 1'b0;
    led_ctrl = 4'b0101;
    tick(1);
    check("led_invert", led, 4'b1010);

    // ADD 5+7: visible after the third edge, not before.
    set_op(0, 2'b00, 5, 7);
    start[0] = 1'b1;
    tick(2);
    check("add_done_early", done[0], 0);
    tick(1);
    check("add_result", result[0 +: WIDTH], 12);
    check("add_model", m_r[0], 12);
    check("add_done", done[0], 1);
    check("add_ovf", ovf[0], 0);
    check("add_count", op_count, 1);

    start[0] = 1'b0;
    set_op(0, 2'b00, 32'hFFFF_FFFF, 2);
    tick(1);
    start[0] = 1'b1;
    tick(3);
    check("ovf_flag", ovf[0], 1);
`ifdef WIRE_ALU_SAT_EN
    check("ovf_result", result[0 +: WIDTH], 32'hFFFF_FFFF);
`else
    check("ovf_result", result[0 +: WIDTH], 1);
`endif
    check("ovf_count", op_count, 2);

    // Second edge lands in EXEC and must be dropped.
    start[0] = 1'b0;
    set_op(0, 2'b00, 1, 1);
    tick(1);
    start[0] = 1'b1; tick(1);
    start[0] = 1'b0; tick(1);
    start[0] = 1'b1; tick(1);
    tick(2);
    check("drop_err", err[0], 1);
    check("drop_result", result[0 +: WIDTH], 2);
    check("drop_count", op_count, 3);
    check("drop_ovf_sticky", ovf[0], 1);

    start[0] = 1'b0;
    set_op(0, 2'b11, 9, 9);
    tick(1);
    start[0] = 1'b1;
    tick(3);
    check("clr_result", result[0 +: WIDTH], 0);
    check("clr_ovf", ovf[0], 0);
    check("clr_err", err[0], 0);
    check("clr_done", done[0], 1);
    check("clr_count", op_count, 4);

    // Two lanes ACC 3 twice in lockstep.
    start = '0;
    set_op(0, 2'b10, 3, 0);
    set_op(1, 2'b10, 3, 0);
    tick(1);
    start[1:0] = 2'b11; tick(3);
    start[1:0] = 2'b00; tick(1);
    start[1:0] = 2'b11; tick(3);
    check("acc_result0", result[0 +: WIDTH], 6);
    check("acc_result1", result[WIDTH +: WIDTH], 6);
    check("acc_count", op_count, 8);
    start = '0;
    tick(2);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = start ^ (NCH'($urandom) & NCH'($urandom));
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_op(c, 2'($urandom), rand_opnd(), rand_opnd());
        end
      end
      led_ctrl = LED_W'($urandom);
      tick(1);
    end
    reset = 1'b0;
    start = '0;
    tick(4);

    // Start held high across reset must not fire.
    reset = 1'b1;
    start = '1;
    tick(3);
    reset = 1'b0;
    tick(4);
    check("hold_done", done, 0);
    check("hold_busy", busy, 0);
    check("hold_count", op_count, 0);

    start = '0;
    set_op(0, 2'b00, 5, 7);
    tick(1);
    start[0] = 1'b1;
    tick(1);
    check("abort_busy", busy[0], 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    start[0] = 1'b0;
    tick(4);
    check("abort_result", result[0 +: WIDTH], 0);
    check("abort_count", op_count, 0);

    // 65536 completions across four lanes, three cycles per round.
    start = '0;
    for (int c = 0; c < NCH; c++) set_op(c, 2'b00, 1, 1);
    tick(1);
    for (int i = 0; i < 65536 / NCH; i++) begin
      if (i == 65536 / NCH - 1) check("wrap_pre", op_count, 16'hFFFC);
      start = '1; tick(1);
      start = '0; tick(2);
    end
    check("wrap_count", op_count, 0);
    check("wrap_model", m_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
